// File: rtl/sram_uart_mem_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : sram_uart_mem_ctrl
// Purpose  : Dual-port memory controller between the pipelined CPU and the
//            board's shared SRAM/UART data bus. An instruction-fetch port and
//            a data port are arbitrated onto one asynchronous SRAM (data port
//            wins ties). The controller sequences the SRAM OE/WE/EN strobes
//            over multi-cycle read and write accesses.
// Revision : 1.0 - arbitrating read/write controller replacing the fixed
//                  two-state fetch-only sequencer
//
// Build option:
//   MEMCTRL_UART_EN  When defined, UART_DATA_ADDR and UART_STAT_ADDR on the
//                    data port decode to the UART data/status registers over
//                    the shared bus. When undefined, those addresses are plain
//                    SRAM, uart_rdn/uart_wrn are tied high and the UART status
//                    inputs are ignored.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and 16-bit word address
//   if_rdata/if_ready         fetched word (held) / one-cycle completion pulse
//   d_rd/d_wr/d_addr/d_wdata  data read/write request (both high = write)
//   d_rdata/d_ready           read data (held) / one-cycle completion pulse
//   ram_en_n/oe_n/we_n        SRAM strobes, active low
//   ram_addr                  SRAM address, zero-extended CPU address
//   ram_data                  shared bidirectional SRAM/UART data bus
//   uart_rdn/uart_wrn         UART strobes, active low
//   uart_data_ready/tbre/tsre UART status inputs
//==============================================================================
module sram_uart_mem_ctrl #(
   parameter int                ADDR_W         = 18,
   parameter int                DATA_W         = 16,
   parameter logic [15:0]       UART_DATA_ADDR = 16'hBF00,
   parameter logic [15:0]       UART_STAT_ADDR = 16'hBF01,
   parameter logic [DATA_W-1:0] NOP_WORD       = 16'h0800
) (
   input  logic              CLK,
   input  logic              RST,
   // instruction fetch port
   input  logic              if_req,
   input  logic [15:0]       if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   // data port
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [15:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   // SRAM side
   output logic              ram_en_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data,
   // UART side
   output logic              uart_rdn,
   output logic              uart_wrn,
   input  logic              uart_data_ready,
   input  logic              uart_tbre,
   input  logic              uart_tsre
);

   // ---------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------
   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_RD         = 4'd1;
   localparam logic [3:0] S_WR_SET     = 4'd2;
   localparam logic [3:0] S_WR_PULSE   = 4'd3;
   localparam logic [3:0] S_WR_HOLD    = 4'd4;
   localparam logic [3:0] S_U_RD       = 4'd5;
   localparam logic [3:0] S_U_WR_SET   = 4'd6;
   localparam logic [3:0] S_U_WR_PULSE = 4'd7;
   localparam logic [3:0] S_DONE       = 4'd8;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   logic [3:0]        state_d, state_q;
   logic              owner_fetch_d, owner_fetch_q;   // 1: current access belongs to fetch port
   logic [15:0]       addr_d, addr_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
   logic [DATA_W-1:0] d_rdata_d, d_rdata_q;
   logic              if_ready_d, if_ready_q;
   logic              d_ready_d, d_ready_q;
   logic              ram_en_n_d, ram_en_n_q;
   logic              ram_oe_n_d, ram_oe_n_q;
   logic              ram_we_n_d, ram_we_n_q;
   logic              drive_d, drive_q;               // controller owns ram_data
   logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;

   // ---------------------------------------------------------------------
   // UART address decode (data port only)
   // ---------------------------------------------------------------------
   logic              uart_data_hit;
   logic              uart_stat_hit;
   logic [DATA_W-1:0] status_word;

`ifdef MEMCTRL_UART_EN
   assign uart_data_hit = (d_addr == UART_DATA_ADDR);
   assign uart_stat_hit = (d_addr == UART_STAT_ADDR);
   // bit1: receive data waiting, bit0: transmitter completely empty
   assign status_word   = {{(DATA_W-2){1'b0}}, uart_data_ready, uart_tbre & uart_tsre};
`else
   logic unused_uart;
   assign uart_data_hit = 1'b0;
   assign uart_stat_hit = 1'b0;
   assign status_word   = '0;
   assign unused_uart   = ^{uart_data_ready, uart_tbre, uart_tsre,
                            UART_DATA_ADDR, UART_STAT_ADDR};
`endif

   // ---------------------------------------------------------------------
   // Arbitration and access sequencing
   // ---------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      owner_fetch_d = owner_fetch_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      if_rdata_d    = if_rdata_q;
      d_rdata_d     = d_rdata_q;

      case (state_q)
         S_IDLE: begin
            // Data port has priority; a losing fetch simply stays asserted
            // and is picked up in the IDLE cycle following DONE.
            if (d_rd || d_wr) begin
               owner_fetch_d = 1'b0;
               addr_d        = d_addr;
               wdata_d       = d_wdata;
               if (uart_stat_hit) begin
                  // Status reads complete immediately; status writes are dropped.
                  state_d = S_DONE;
                  if (!d_wr) begin
                     d_rdata_d = status_word;
                  end
               end else if (uart_data_hit) begin
                  state_d = d_wr ? S_U_WR_SET : S_U_RD;
               end else begin
                  state_d = d_wr ? S_WR_SET : S_RD;
               end
            end else if (if_req) begin
               owner_fetch_d = 1'b1;
               addr_d        = if_addr;
               state_d       = S_RD;
            end
         end

         S_RD: begin
            // SRAM output is valid while OE is low; capture on the way out.
            if (owner_fetch_q) begin
               if_rdata_d = ram_data;
            end else begin
               d_rdata_d  = ram_data;
            end
            state_d = S_DONE;
         end

         S_WR_SET:     state_d = S_WR_PULSE;
         S_WR_PULSE:   state_d = S_WR_HOLD;
         S_WR_HOLD:    state_d = S_DONE;

         S_U_RD: begin
            d_rdata_d = ram_data;
            state_d   = S_DONE;
         end

         S_U_WR_SET:   state_d = S_U_WR_PULSE;
         S_U_WR_PULSE: state_d = S_DONE;
         S_DONE:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, so every strobe and ready leaves a
   // flop and is glitch-free on the board.
   // ---------------------------------------------------------------------
   always_comb begin
      ram_en_n_d = !((state_d == S_RD)       || (state_d == S_WR_SET) ||
                     (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD));
      ram_oe_n_d = (state_d != S_RD);
      // WE only pulses in the middle cycle so address and data have setup
      // and hold around the write edge.
      ram_we_n_d = (state_d != S_WR_PULSE);
      drive_d    = (state_d == S_WR_SET)   || (state_d == S_WR_PULSE) ||
                   (state_d == S_WR_HOLD)  || (state_d == S_U_WR_SET) ||
                   (state_d == S_U_WR_PULSE);
      if_ready_d = (state_d == S_DONE) &&  owner_fetch_d;
      d_ready_d  = (state_d == S_DONE) && !owner_fetch_d;
      ram_addr_d = ADDR_W'(addr_d);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         owner_fetch_q <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         if_rdata_q    <= NOP_WORD;
         d_rdata_q     <= '0;
         if_ready_q    <= 1'b0;
         d_ready_q     <= 1'b0;
         ram_en_n_q    <= 1'b1;
         ram_oe_n_q    <= 1'b1;
         ram_we_n_q    <= 1'b1;
         drive_q       <= 1'b0;
         ram_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         owner_fetch_q <= owner_fetch_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         if_rdata_q    <= if_rdata_d;
         d_rdata_q     <= d_rdata_d;
         if_ready_q    <= if_ready_d;
         d_ready_q     <= d_ready_d;
         ram_en_n_q    <= ram_en_n_d;
         ram_oe_n_q    <= ram_oe_n_d;
         ram_we_n_q    <= ram_we_n_d;
         drive_q       <= drive_d;
         ram_addr_q    <= ram_addr_d;
      end
   end

   // ---------------------------------------------------------------------
   // UART strobes
   // ---------------------------------------------------------------------
`ifdef MEMCTRL_UART_EN
   logic uart_rdn_d, uart_rdn_q;
   logic uart_wrn_d, uart_wrn_q;

   always_comb begin
      uart_rdn_d = (state_d != S_U_RD);
      uart_wrn_d = (state_d != S_U_WR_PULSE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         uart_rdn_q <= 1'b1;
         uart_wrn_q <= 1'b1;
      end else begin
         uart_rdn_q <= uart_rdn_d;
         uart_wrn_q <= uart_wrn_d;
      end
   end

   assign uart_rdn = uart_rdn_q;
   assign uart_wrn = uart_wrn_q;
`else
   assign uart_rdn = 1'b1;
   assign uart_wrn = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign if_rdata = if_rdata_q;
   assign if_ready = if_ready_q;
   assign d_rdata  = d_rdata_q;
   assign d_ready  = d_ready_q;
   assign ram_en_n = ram_en_n_q;
   assign ram_oe_n = ram_oe_n_q;
   assign ram_we_n = ram_we_n_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_uart_mem_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_sram_uart_mem_ctrl
// Purpose  : Self-checking bench for sram_uart_mem_ctrl. Contains a behavioural
//            SRAM/UART bus model and a transaction-level reference model
//            (memory contents, per-access latency and strobe-cycle budget).
// Revision : 1.0 - initial bench
//==============================================================================
module tb_sram_uart_mem_ctrl;
   localparam int          AW    = 18;
   localparam int          DW    = 16;
   localparam logic [15:0] UDATA = 16'hBF00;
   localparam logic [15:0] USTAT = 16'hBF01;

   // access kinds of the reference model
   localparam int K_RD = 0, K_WR = 1, K_URD = 2, K_UWR = 3, K_SRD = 4, K_SWR = 5;

   logic          CLK = 1'b0;
   logic          RST;
   logic          if_req;
   logic [15:0]   if_addr;
   wire  [DW-1:0] if_rdata;
   wire           if_ready;
   logic          d_rd, d_wr;
   logic [15:0]   d_addr;
   logic [DW-1:0] d_wdata;
   wire  [DW-1:0] d_rdata;
   wire           d_ready;
   wire           ram_en_n, ram_oe_n, ram_we_n;
   wire  [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;
   wire           uart_rdn, uart_wrn;
   logic          uart_data_ready, uart_tbre, uart_tsre;

   sram_uart_mem_ctrl dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
      .ram_addr(ram_addr), .ram_data(ram_data),
      .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
      .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
   );

   always #5 CLK = ~CLK;

   // ------------------------------------------------------------------
   // Bookkeeping and checker
   // ------------------------------------------------------------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Board model: SRAM + UART sharing the data bus
   // ------------------------------------------------------------------
   function automatic logic [15:0] init_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h3C5A;
   endfunction

   logic [15:0] sram [int];
   logic        preset_en = 1'b0;
   logic [15:0] preset_addr, preset_val;
   logic [15:0] uart_rx;
   logic [15:0] last_tx = '0;
   int          tx_cnt  = 0;

   function automatic logic [15:0] sram_read(input logic [15:0] a);
      if (sram.exists(int'(a))) return sram[int'(a)];
      return init_word(a);
   endfunction

   logic [15:0] bus_val;
   logic        bus_oe;
   always_comb begin
      bus_oe  = 1'b0;
      bus_val = '0;
      if (!ram_en_n && !ram_oe_n) begin
         bus_oe  = 1'b1;
         bus_val = sram_read(ram_addr[15:0]);
      end else if (!uart_rdn) begin
         bus_oe  = 1'b1;
         bus_val = uart_rx;
      end
   end
   assign ram_data = bus_oe ? bus_val : 'z;

   always @(posedge CLK) begin
      if (preset_en) sram[int'(preset_addr)] = preset_val;
      if (!ram_en_n && !ram_we_n) sram[int'(ram_addr[15:0])] = ram_data;
      if (!uart_wrn) begin
         last_tx = ram_data;
         tx_cnt  = tx_cnt + 1;
      end
   end

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   logic [15:0] ref_mem [int];
   logic [15:0] exp_ird;
   logic [15:0] exp_drd;

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_word(a);
   endfunction

   function automatic int classify(input bit wr, input logic [15:0] a);
`ifdef MEMCTRL_UART_EN
      if (a == USTAT) return wr ? K_SWR : K_SRD;
      if (a == UDATA) return wr ? K_UWR : K_URD;
`endif
      return wr ? K_WR : K_RD;
   endfunction

   // ------------------------------------------------------------------
   // Transactions
   // ------------------------------------------------------------------
   task automatic data_access(input bit wr, input logic [15:0] a, input logic [15:0] wd);
      int k, lat, en_c, oe_c, we_c, rdn_c, wrn_c, bus_bad, addr_bad, coll, stray, tx0;
      int e_lat, e_en, e_oe, e_we, e_rdn, e_wrn;
      bit done;
      k = classify(wr, a);
      case (k)
         K_RD:    begin e_lat = 2; e_en = 1; e_oe = 1; e_we = 0; e_rdn = 0; e_wrn = 0; end
         K_WR:    begin e_lat = 4; e_en = 3; e_oe = 0; e_we = 1; e_rdn = 0; e_wrn = 0; end
         K_URD:   begin e_lat = 2; e_en = 0; e_oe = 0; e_we = 0; e_rdn = 1; e_wrn = 0; end
         K_UWR:   begin e_lat = 3; e_en = 0; e_oe = 0; e_we = 0; e_rdn = 0; e_wrn = 1; end
         default: begin e_lat = 1; e_en = 0; e_oe = 0; e_we = 0; e_rdn = 0; e_wrn = 0; end
      endcase
      case (k)
         K_RD:  exp_drd = ref_read(a);
         K_WR:  ref_mem[int'(a)] = wd;
         K_URD: exp_drd = uart_rx;
         K_SRD: exp_drd = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
         default: ;
      endcase
      @(negedge CLK);
      d_rd = !wr; d_wr = wr; d_addr = a; d_wdata = wd;
      tx0 = tx_cnt;
      lat = 0; done = 0; en_c = 0; oe_c = 0; we_c = 0; rdn_c = 0; wrn_c = 0;
      bus_bad = 0; addr_bad = 0; coll = 0; stray = 0;
      while (!done && lat < 12) begin
         @(posedge CLK); #1; lat++;
         if (!ram_en_n) en_c++;
         if (!ram_oe_n) oe_c++;
         if (!ram_we_n) we_c++;
         if (!uart_rdn) rdn_c++;
         if (!uart_wrn) wrn_c++;
         if (!ram_en_n && ram_oe_n && ram_data !== wd) bus_bad++;
         if (!uart_wrn && ram_data !== wd) bus_bad++;
         if (!ram_en_n && ram_addr !== AW'(a)) addr_bad++;
         if (!ram_en_n && (!uart_rdn || !uart_wrn)) coll++;
         if (if_ready) stray++;
         if (d_ready) done = 1;
      end
      d_rd = 0; d_wr = 0;
      chk("d_latency", lat, e_lat);
      chk("d_rdata", d_rdata, exp_drd);
      chk("if_rdata_held", if_rdata, exp_ird);
      chk("en_cycles", en_c, e_en);
      chk("oe_cycles", oe_c, e_oe);
      chk("we_cycles", we_c, e_we);
      chk("uart_rdn_cycles", rdn_c, e_rdn);
      chk("uart_wrn_cycles", wrn_c, e_wrn);
      chk("write_bus_value", bus_bad, 0);
      chk("ram_addr", addr_bad, 0);
      chk("sram_uart_overlap", coll, 0);
      chk("stray_if_ready", stray, 0);
      chk("uart_tx_count", tx_cnt - tx0, e_wrn);
      if (e_wrn != 0) chk("uart_tx_data", last_tx, wd);
      @(posedge CLK); #1;
      chk("ready_one_cycle", {if_ready, d_ready}, 0);
   endtask

   task automatic fetch_access(input logic [15:0] a);
      int lat, en_c, oe_c, we_c, addr_bad, stray;
      bit done;
      exp_ird = ref_read(a);
      @(negedge CLK);
      if_req = 1; if_addr = a;
      lat = 0; done = 0; en_c = 0; oe_c = 0; we_c = 0; addr_bad = 0; stray = 0;
      while (!done && lat < 12) begin
         @(posedge CLK); #1; lat++;
         if (!ram_en_n) en_c++;
         if (!ram_oe_n) oe_c++;
         if (!ram_we_n) we_c++;
         if (!ram_en_n && ram_addr !== AW'(a)) addr_bad++;
         if (d_ready) stray++;
         if (if_ready) done = 1;
      end
      if_req = 0;
      chk("if_latency", lat, 2);
      chk("if_rdata", if_rdata, exp_ird);
      chk("d_rdata_held", d_rdata, exp_drd);
      chk("if_en_cycles", en_c, 1);
      chk("if_oe_cycles", oe_c, 1);
      chk("if_we_cycles", we_c, 0);
      chk("if_ram_addr", addr_bad, 0);
      chk("stray_d_ready", stray, 0);
      @(posedge CLK); #1;
      chk("ready_one_cycle", {if_ready, d_ready}, 0);
   endtask

   // Fetch and data read raised together: data first, fetch after it.
   task automatic dual_read(input logic [15:0] fa, input logic [15:0] da);
      int td, ti;
      exp_drd = ref_read(da);
      exp_ird = ref_read(fa);
      @(negedge CLK);
      if_req = 1; if_addr = fa; d_rd = 1; d_addr = da;
      td = 0; ti = 0;
      for (int t = 1; t <= 14 && ti == 0; t++) begin
         @(posedge CLK); #1;
         if (d_ready)  begin td = t; d_rd = 0; end
         if (if_ready) begin ti = t; if_req = 0; end
      end
      if_req = 0; d_rd = 0;
      chk("dual_d_ready_cycle", td, 2);
      chk("dual_if_ready_cycle", ti, 5);
      chk("dual_d_rdata", d_rdata, exp_drd);
      chk("dual_if_rdata", if_rdata, exp_ird);
      @(posedge CLK);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_strobes"}, {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
      chk({tag, "_if_rdata"}, if_rdata, 16'h0800);
      chk({tag, "_d_rdata"}, d_rdata, 16'h0000);
      chk({tag, "_ready"}, {if_ready, d_ready}, 2'b00);
      chk({tag, "_ram_addr"}, ram_addr, 0);
   endtask

   // Reset asserted while the write pulse is active.
   task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] wd);
      @(negedge CLK);
      d_wr = 1; d_addr = a; d_wdata = wd;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("pre_reset_we_low", ram_we_n, 1'b0);
      @(negedge CLK);
      RST = 1;
      @(posedge CLK); #1;
      // the SRAM saw WE low through the reset edge, so the word is written
      ref_mem[int'(a)] = wd;
      exp_ird = 16'h0800;
      exp_drd = 16'h0000;
      check_reset_outputs("mid_write_reset");
      @(negedge CLK);
      d_wr = 0; RST = 0;
      @(posedge CLK); #1;
      chk("post_reset_no_ready", {if_ready, d_ready}, 2'b00);
   endtask

   function automatic logic [15:0] pick_addr(input bit data_port);
      int r;
      r = $urandom_range(0, 9);
      if (data_port && r == 0) return UDATA;
      if (data_port && r == 1) return USTAT;
      return 16'h8000 + 16'($urandom_range(0, 15));
   endfunction

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      RST = 1; if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
      uart_data_ready = 0; uart_tbre = 0; uart_tsre = 0; uart_rx = 16'h0000;
      preset_addr = '0; preset_val = '0;
      exp_ird = 16'h0800; exp_drd = 16'h0000;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK);
      RST = 0;

      // fetch from 0x0010 with SRAM holding 0x4A21
      @(negedge CLK);
      preset_en = 1; preset_addr = 16'h0010; preset_val = 16'h4A21;
      ref_mem[16'h0010] = 16'h4A21;
      @(posedge CLK); #1;
      preset_en = 0;
      fetch_access(16'h0010);
      chk("fetch_4a21", if_rdata, 16'h4A21);

      // write 0x1234 to 0x8000 then read it back
      data_access(1'b1, 16'h8000, 16'h1234);
      data_access(1'b0, 16'h8000, 16'h0000);
      chk("readback_1234", d_rdata, 16'h1234);

      // simultaneous fetch and data read
      dual_read(16'h0010, 16'h8000);

`ifdef MEMCTRL_UART_EN
      uart_data_ready = 1; uart_tbre = 1; uart_tsre = 0;
      data_access(1'b0, USTAT, 16'h0000);
      chk("status_word", d_rdata, 16'h0002);
      data_access(1'b1, UDATA, 16'h0041);
      uart_rx = 16'h00C3;
      data_access(1'b0, UDATA, 16'h0000);
`else
      data_access(1'b1, 16'hBF00, 16'h5A5A);
      data_access(1'b0, 16'hBF00, 16'h0000);
      chk("bf00_is_sram", d_rdata, 16'h5A5A);
`endif

      reset_mid_write(16'h8003, 16'hBEEF);
      data_access(1'b0, 16'h8003, 16'h0000);

      // randomized mix of fetches, reads and writes
      for (int i = 0; i < 60; i++) begin
         uart_data_ready = 1'($urandom_range(0, 1));
         uart_tbre       = 1'($urandom_range(0, 1));
         uart_tsre       = 1'($urandom_range(0, 1));
         uart_rx         = 16'($urandom);
         case ($urandom_range(0, 3))
            0: fetch_access(pick_addr(1'b0));
            1: data_access(1'b0, pick_addr(1'b1), 16'h0000);
            2: data_access(1'b1, pick_addr(1'b1), 16'($urandom));
            default: dual_read(pick_addr(1'b0), 16'h8000 + 16'($urandom_range(0, 15)));
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
